// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller for a dual-clock FIFO: write pointer (binary and Gray),
// read-pointer synchroniser, registered full/almost-full/level flags and a sticky overflow flag.
module fifo_wr_ctrl #(
  parameter int ADDRSIZE     = 9,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
  input  logic              wclk,
  input  logic              w_rst,
  input  logic              winc,
  input  logic [ADDRSIZE:0] rptr_gray,
  input  logic              ovf_clr,
  output logic [ADDRSIZE:0] waddr,
  output logic [ADDRSIZE:0] wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDRSIZE:0] wlevel,
  output logic              woverflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] wq1, wq2;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] wbin_next, wgray_next;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_gray;
  logic          wen;

  assign wen        = winc & ~wfull;
  assign wbin_next  = waddr + PW'(wen);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign level_next = wbin_next - rbin_sync;

  // Full when the write pointer is one lap ahead: Gray of (rptr ^ MSB) flips the top two bits.
  assign full_gray = {~wq2[ADDRSIZE:ADDRSIZE-1], wq2[ADDRSIZE-2:0]};

  always_comb begin
    rbin_sync = wq2;
    for (int s = 1; s < PW; s++) begin
      rbin_sync = rbin_sync ^ (wq2 >> s);
    end
  end

  always_ff @(posedge wclk or negedge w_rst) begin
    if (!w_rst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= rptr_gray;
      wq2 <= wq1;
    end
  end

  always_ff @(posedge wclk or negedge w_rst) begin
    if (!w_rst) begin
      waddr        <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      waddr        <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= (wgray_next == full_gray);
      walmost_full <= (level_next >= AFULL_T);
      wlevel       <= level_next;
      // A new overflow takes priority over a clear in the same cycle.
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (ovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (ADDRSIZE=9): a count-based occupancy model
// pushes the expected outputs per edge; each scenario task pops and compares.
module tb_fifo_wr_ctrl;

  localparam int AW = 9;

  typedef struct packed {
    logic [AW:0] waddr;
    logic [AW:0] wgray;
    logic [AW:0] wlevel;
    logic        wfull;
    logic        afull;
    logic        ovf;
  } exp_t;

  logic          wclk = 1'b0;
  logic          w_rst = 1'b0;
  logic          winc = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   rptr_bin = '0;
  logic [AW:0]   rptr_gray;
  logic [AW:0]   waddr, wptr_gray, wlevel;
  logic          wfull, walmost_full, woverflow;
  exp_t          dut_obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [AW:0] m_waddr, m_rs1, m_rs2;
  logic        m_wfull, m_ovf;
  exp_t        sb[$];

  assign rptr_gray = rptr_bin ^ (rptr_bin >> 1);
  assign dut_obs   = {waddr, wptr_gray, wlevel, wfull, walmost_full, woverflow};

  always #5 wclk = ~wclk;

  fifo_wr_ctrl #(.ADDRSIZE(AW)) dut (
    .wclk(wclk), .w_rst(w_rst), .winc(winc), .rptr_gray(rptr_gray), .ovf_clr(ovf_clr),
    .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  task automatic model_reset();
    m_waddr = '0; m_rs1 = '0; m_rs2 = '0; m_wfull = 1'b0; m_ovf = 1'b0;
    sb.delete();
  endtask

  // One wclk edge: the model consumes the inputs present at the edge and queues the expected outputs.
  task automatic step();
    exp_t        e;
    logic [AW:0] lvl;
    logic        wen_m;
    @(posedge wclk);
    wen_m = winc && !m_wfull;
    if (winc && m_wfull) m_ovf = 1'b1;
    else if (ovf_clr)    m_ovf = 1'b0;
    m_waddr = m_waddr + {{AW{1'b0}}, wen_m};
    lvl     = m_waddr - m_rs2;
    m_wfull = (lvl == 10'd512);
    e.waddr  = m_waddr;
    e.wgray  = m_waddr ^ (m_waddr >> 1);
    e.wlevel = lvl;
    e.wfull  = m_wfull;
    e.afull  = (lvl >= 10'd508);
    e.ovf    = m_ovf;
    m_rs2 = m_rs1;
    m_rs1 = rptr_bin;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    w_rst = 1'b0; winc = 1'b1; ovf_clr = 1'b0; rptr_bin = '0;
    repeat (2) @(posedge wclk);
    #1;
    n_checks++;
    if (dut_obs !== '0) begin
      n_fail++; $display("FAIL reset_state actual=%h required=0", dut_obs);
    end
    model_reset();
    winc = 1'b0;
    w_rst = 1'b1;
    step();
    n_checks++;
    if (dut_obs !== sb.pop_front()) begin
      n_fail++; $display("FAIL reset_idle actual=%h required_zero_state", dut_obs);
    end
  endtask

  task automatic test_fill();
    exp_t e;
    winc = 1'b1; rptr_bin = '0;
    for (int i = 1; i <= 512; i++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (dut_obs !== e) begin
        n_fail++; $display("FAIL fill_write%0d actual=%h required=%h", i, dut_obs, e);
      end
      if (i == 507) begin
        n_checks++;
        if (walmost_full !== 1'b0 || wlevel !== 10'd507) begin
          n_fail++; $display("FAIL fill_afull_507 afull=%b level=%0d required 0/507", walmost_full, wlevel);
        end
      end
      if (i == 508) begin
        n_checks++;
        if (walmost_full !== 1'b1 || wlevel !== 10'd508) begin
          n_fail++; $display("FAIL fill_afull_508 afull=%b level=%0d required 1/508", walmost_full, wlevel);
        end
      end
      if (i == 511) begin
        n_checks++;
        if (wfull !== 1'b0) begin
          n_fail++; $display("FAIL fill_early_full wfull=%b required 0", wfull);
        end
      end
    end
    n_checks++;
    if (wfull !== 1'b1 || waddr !== 10'h200 || wptr_gray !== 10'h300 || wlevel !== 10'd512) begin
      n_fail++;
      $display("FAIL fill_end wfull=%b waddr=%h gray=%h level=%0d required 1/200/300/512",
               wfull, waddr, wptr_gray, wlevel);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    winc = 1'b1; ovf_clr = 1'b0;
    repeat (3) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (dut_obs !== e) begin
        n_fail++; $display("FAIL ovf_write actual=%h required=%h", dut_obs, e);
      end
    end
    n_checks++;
    if (waddr !== 10'h200 || woverflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set waddr=%h ovf=%b required 200/1", waddr, woverflow);
    end
    winc = 1'b0; ovf_clr = 1'b1;
    step();
    e = sb.pop_front();
    n_checks++;
    if (woverflow !== 1'b0 || dut_obs !== e) begin
      n_fail++; $display("FAIL ovf_clear actual=%h required=%h", dut_obs, e);
    end
    winc = 1'b1; ovf_clr = 1'b0;
    step();
    void'(sb.pop_front());
    winc = 1'b1; ovf_clr = 1'b1;
    step();
    e = sb.pop_front();
    n_checks++;
    if (woverflow !== 1'b1 || dut_obs !== e) begin
      n_fail++; $display("FAIL ovf_set_wins actual=%h required=%h", dut_obs, e);
    end
    winc = 1'b0; ovf_clr = 1'b1;
    step();
    void'(sb.pop_front());
    ovf_clr = 1'b0;
  endtask

  task automatic test_read_release();
    exp_t e;
    winc = 1'b0;
    rptr_bin = 10'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (dut_obs !== e) begin
        n_fail++; $display("FAIL release_edge%0d actual=%h required=%h", k, dut_obs, e);
      end
      n_checks++;
      if (k < 2 && (wfull !== 1'b1 || wlevel !== 10'd512)) begin
        n_fail++; $display("FAIL release_early edge%0d wfull=%b level=%0d required 1/512", k, wfull, wlevel);
      end else if (k == 2 && (wfull !== 1'b0 || wlevel !== 10'd511)) begin
        n_fail++; $display("FAIL release_late wfull=%b level=%0d required 0/511", wfull, wlevel);
      end
    end
    winc = 1'b1;
    step();
    e = sb.pop_front();
    winc = 1'b0;
    n_checks++;
    if (waddr !== 10'h201 || wfull !== 1'b1 || dut_obs !== e) begin
      n_fail++; $display("FAIL release_refill actual=%h required=%h", dut_obs, e);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   budget = 700;
    while (m_waddr != 10'h3FF && budget > 0) begin
      winc     = 1'b1;
      rptr_bin = (m_waddr - 10'd1 > 10'h3FE) ? 10'h3FE : m_waddr - 10'd1;
      step();
      e = sb.pop_front();
      n_checks++;
      if (dut_obs !== e) begin
        n_fail++; $display("FAIL wrap_traffic actual=%h required=%h", dut_obs, e);
      end
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++; $display("FAIL wrap_budget waddr=%h required 3ff within budget", waddr);
    end
    winc = 1'b0; rptr_bin = 10'h3FE;
    repeat (3) begin
      step();
      void'(sb.pop_front());
    end
    n_checks++;
    if (waddr !== 10'h3FF || wlevel !== 10'd1) begin
      n_fail++; $display("FAIL wrap_preset waddr=%h level=%0d required 3ff/1", waddr, wlevel);
    end
    winc = 1'b1;
    step();
    e = sb.pop_front();
    winc = 1'b0;
    n_checks++;
    if (waddr !== 10'h000 || wptr_gray !== 10'h000 || wlevel !== 10'd2 || wfull !== 1'b0 || dut_obs !== e) begin
      n_fail++; $display("FAIL wrap_roll actual=%h required waddr=0 gray=0 level=2 full=0", dut_obs);
    end
  endtask

  task automatic test_level_random();
    exp_t        e;
    logic        prev_full;
    logic [AW:0] prev_addr;
    for (int i = 0; i < 1600; i++) begin
      if (i < 800) begin
        winc = ($urandom_range(0, 3) != 0);
        if (rptr_bin != m_waddr && $urandom_range(0, 2) == 0) rptr_bin = rptr_bin + 10'd1;
      end else begin
        winc = ($urandom_range(0, 3) == 0);
        if (rptr_bin != m_waddr && $urandom_range(0, 2) != 0) rptr_bin = rptr_bin + 10'd1;
      end
      prev_full = wfull;
      prev_addr = waddr;
      step();
      e = sb.pop_front();
      n_checks++;
      if (dut_obs !== e) begin
        n_fail++; $display("FAIL random_cycle%0d actual=%h required=%h", i, dut_obs, e);
      end
      if (winc && prev_full) begin
        n_checks++;
        if (waddr !== prev_addr) begin
          n_fail++; $display("FAIL random_write_while_full waddr=%h required=%h", waddr, prev_addr);
        end
      end
    end
    winc = 1'b0;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    winc = 1'b1; rptr_bin = m_waddr;
    repeat (3) begin
      step();
      void'(sb.pop_front());
    end
    #3;
    w_rst = 1'b0;
    #1;
    n_checks++;
    if (dut_obs !== '0) begin
      n_fail++; $display("FAIL midreset_async actual=%h required=0", dut_obs);
    end
    repeat (2) begin
      @(posedge wclk);
      #1;
      n_checks++;
      if (dut_obs !== '0) begin
        n_fail++; $display("FAIL midreset_hold actual=%h required=0", dut_obs);
      end
    end
    model_reset();
    rptr_bin = '0;
    w_rst = 1'b1;
    step();
    e = sb.pop_front();
    winc = 1'b0;
    n_checks++;
    if (waddr !== 10'd1 || dut_obs !== e) begin
      n_fail++; $display("FAIL midreset_resume actual=%h required=%h", dut_obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_level_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
